por_reset_sequencer: RTL and testbench



---
 rtl/por_seq_pkg.sv | 16 +
 rtl/por_seq_filter.sv | 46 ++++
 rtl/por_reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_por_reset_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/por_seq_pkg.sv
// Shared state encoding and default parameters for the power-on-reset sequencer.
package por_seq_pkg;

  typedef enum logic [1:0] {
    SeqWaitPor = 2'd0,
    SeqStretch = 2'd1,
    SeqRelease = 2'd2,
    SeqRun     = 2'd3
  } por_seq_state_e;

  localparam int unsigned DefNCh      = 4;
  localparam int unsigned DefCntW     = 16;
  localparam int unsigned DefStretch  = 1024;
  localparam int unsigned DefFiltLen  = 4;

endpackage

// File: rtl/por_seq_filter.sv
// Two-flop synchroniser plus consecutive-high deglitch counter for the POR cell output.
module por_seq_filter
  import por_seq_pkg::*;
#(
  parameter int unsigned FILT_LEN = DefFiltLen
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic por_n_i,
  output logic por_ok_o
);

  localparam logic [3:0] FiltMax = 4'(FILT_LEN);

  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d;
  logic       ok_q, ok_d;
  logic       por_s;

  assign por_s = sync_q[1];

  // Count saturates at FiltMax so a long-stable POR keeps por_ok asserted.
  always_comb begin
    cnt_d = '0;
    ok_d  = 1'b0;
    if (por_s) begin
      cnt_d = (cnt_q == FiltMax) ? cnt_q : cnt_q + 4'd1;
      ok_d  = (cnt_d == FiltMax);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ok_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], por_n_i};
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
    end
  end

  assign por_ok_o = ok_q;

endmodule

// File: rtl/por_reset_sequencer.sv
// Multi-channel POR sequencer: qualify POR, stretch, then release channels in ascending order.
// Define POR_SEQ_SW_RST_EN to let sw_rst_req_i re-run the sequence from RUN.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned N_CH     = DefNCh,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned STRETCH  = DefStretch,
  parameter int unsigned FILT_LEN = DefFiltLen
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  por_n_i,
  input  logic                  sw_rst_req_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [N_CH*CNT_W-1:0] ch_dly_i,
  output logic [N_CH-1:0]       rst_n_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  localparam logic [1:0] StWaitPor = SeqWaitPor;
  localparam logic [1:0] StStretch = SeqStretch;
  localparam logic [1:0] StRelease = SeqRelease;
  localparam logic [1:0] StRun     = SeqRun;

  localparam int unsigned      IdxW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] StretchLast = CNT_W'(STRETCH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]  rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic             por_ok;
  logic             cur_en;
  logic [CNT_W-1:0] cur_dly;
  logic             sw_req;

  por_seq_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .por_n_i  (por_n_i),
    .por_ok_o (por_ok)
  );

`ifdef POR_SEQ_SW_RST_EN
  assign sw_req = sw_rst_req_i;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req_i;
  assign sw_req            = 1'b0;
`endif

  always_comb begin
    cur_en  = 1'b0;
    cur_dly = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_en  = ch_en_i[i];
        cur_dly = ch_dly_i[i*CNT_W +: CNT_W];
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    case (state_q)
      StWaitPor: begin
        if (por_ok) begin
          state_d = StStretch;
          cnt_d   = '0;
        end
      end
      StStretch: begin
        if (cnt_q == StretchLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease: begin
        if (!cur_en || (cnt_q == cur_dly)) begin
          for (int i = 0; i < N_CH; i++) begin
            if (idx_q == IdxW'(i)) rst_n_d[i] = cur_en;
          end
          cnt_d = '0;
          if (idx_q == IdxW'(N_CH - 1)) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRun: begin
        if (sw_req) begin
          state_d = StStretch;
          cnt_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = StWaitPor;
    endcase
    // Losing POR overrides everything, including a same-cycle software request.
    if (!por_ok && (state_q != StWaitPor)) begin
      state_d = StWaitPor;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StWaitPor;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Scoreboard bench: a timeline model predicts every output change; a monitor checks them.
module tb_por_reset_sequencer;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int STR = 1024;
  localparam int FL  = 4;
  localparam int OW  = N + 3;
  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    int            lo;
    int            hi;
    logic [OW-1:0] obs;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_n, por_n, sw;
  logic [N-1:0]   en;
  logic [N*W-1:0] dly;
  logic [N-1:0]   rst_n_o;
  logic           done_o;
  logic [1:0]     state_o;

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            last_hi = 0;
  bit            mon_en = 1'b0;
  bit            in_run = 1'b0;
  logic [OW-1:0] last_obs = '0;
  logic [OW-1:0] prev_obs = '0;
  ev_t           sb_q[$];
  ev_t           seq_q[$];

  por_reset_sequencer #(
    .N_CH     (N),
    .CNT_W    (W),
    .STRETCH  (STR),
    .FILT_LEN (FL)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .por_n_i      (por_n),
    .sw_rst_req_i (sw),
    .ch_en_i      (en),
    .ch_dly_i     (dly),
    .rst_n_o      (rst_n_o),
    .done_o       (done_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] mk(input logic [N-1:0] r, input logic d,
                                       input logic [1:0] s);
    return {r, d, s};
  endfunction

  function automatic ev_t ev(input int lo, input int hi, input logic [OW-1:0] o);
    ev_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.obs = o;
    return e;
  endfunction

  // Only changes are observable, so drop events that repeat the previous expectation.
  function automatic void push_ev(input ev_t e);
    if (e.obs != last_obs) begin
      sb_q.push_back(e);
      last_obs = e.obs;
      if (e.hi > last_hi) last_hi = e.hi;
    end
  endfunction

  // Timeline of one sequence whose STRETCH state starts at edge s.
  function automatic void build_seq(input int s, input logic [N-1:0] e,
                                    input logic [N*W-1:0] dl);
    logic [N-1:0] r;
    int t;
    seq_q.delete();
    r = '0;
    seq_q.push_back(ev(s, s, mk('0, 1'b0, 2'd1)));
    t = s + STR;
    seq_q.push_back(ev(t, t, mk('0, 1'b0, 2'd2)));
    for (int i = 0; i < N; i++) begin
      t += e[i] ? int'(dl[i*W +: W]) + 1 : 1;
      r[i] = e[i];
      seq_q.push_back(ev(t, t, mk(r, (i == N - 1), (i == N - 1) ? 2'd3 : 2'd2)));
    end
  endfunction

  function automatic void push_upto(input int limit);
    while (seq_q.size() != 0 && seq_q[0].lo <= limit) push_ev(seq_q.pop_front());
    seq_q.delete();
  endfunction

  // Move a cut point so no planned event falls inside the POR-loss latency window.
  function automatic int safe_cut(input int d0);
    int d;
    bit hit;
    d = d0;
    do begin
      hit = 1'b0;
      foreach (seq_q[k]) if (seq_q[k].lo > d && seq_q[k].lo <= d + 4) hit = 1'b1;
      if (hit) d++;
    end while (hit);
    return d;
  endfunction

  function automatic logic [N*W-1:0] rand_dly();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, 40));
    return v;
  endfunction

  always @(negedge clk) begin
    logic [OW-1:0] o;
    ev_t e;
    if (mon_en) begin
      o = {rst_n_o, done_o, state_o};
      if (o !== prev_obs) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, o);
        end else begin
          e = sb_q.pop_front();
          if (o !== e.obs || cyc < e.lo || cyc > e.hi) begin
            bad++;
            $display("FAIL event cyc=%0d got=%b want=%b at cyc %0d..%0d",
                     cyc, o, e.obs, e.lo, e.hi);
          end
        end
        prev_obs = o;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic drain();
    while (sb_q.size() != 0 && cyc <= last_hi + 10) step(1);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, sb_q.size());
      sb_q.delete();
    end
    step(3);
    total++;
    if ({rst_n_o, done_o, state_o} !== last_obs) begin
      bad++;
      $display("FAIL steady cyc=%0d got=%b want=%b", cyc, {rst_n_o, done_o, state_o}, last_obs);
    end
  endtask

  // mode 0: complete; 1: POR drop near S+arg; 2: block reset at S+arg; 3: ignored SW pulse.
  task automatic seq_por(input logic [N-1:0] e, input logic [N*W-1:0] dl,
                         input int glitch_h, input int mode, input int arg);
    int c, s, d;
    en  = e;
    dly = dl;
    c   = cyc + ((glitch_h > 0) ? glitch_h + 2 : 0);
    s   = c + 3 + FL;
    d   = s + arg;
    build_seq(s, e, dl);
    case (mode)
      1: begin
        d = safe_cut(d);
        push_upto(d);
        push_ev(ev(d + 1, d + 4, '0));
      end
      2: begin
        push_upto(d);
        push_ev(ev(d + 1, d + 1, '0));
        build_seq(d + 4 + FL, e, dl);
        push_upto(BIG);
      end
      default: push_upto(BIG);
    endcase
    if (glitch_h > 0) begin
      por_n = 1'b1;
      step(glitch_h);
      por_n = 1'b0;
      step(2);
    end
    por_n = 1'b1;
    case (mode)
      1: begin
        wait_until(d);
        por_n = 1'b0;
        step(6);
      end
      2: begin
        wait_until(d);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      3: begin
        wait_until(d);
        sw = 1'b1;
        step(1);
        sw = 1'b0;
      end
      default: ;
    endcase
    drain();
    in_run = (mode != 1);
  endtask

  task automatic drop_from_run();
    int d;
    d = cyc + 2;
    push_ev(ev(d + 1, d + 4, '0));
    wait_until(d);
    por_n = 1'b0;
    step(6);
    drain();
    in_run = 1'b0;
  endtask

  task automatic sw_reseq(input logic [N-1:0] e, input logic [N*W-1:0] dl);
    int s;
    en  = e;
    dly = dl;
    s   = cyc + 2;
`ifdef POR_SEQ_SW_RST_EN
    build_seq(s + 1, e, dl);
    push_upto(BIG);
`endif
    wait_until(s);
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    step(20);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    por_n = 1'b0;
    sw    = 1'b0;
    en    = '0;
    dly   = '0;
    step(3);
    total++;
    if ({rst_n_o, done_o, state_o} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", {rst_n_o, done_o, state_o}, {OW{1'b0}});
    end
    rst_n    = 1'b1;
    prev_obs = '0;
    last_obs = '0;
    mon_en   = 1'b1;
    step(4);

    seq_por(4'b1111, '0, 0, 0, 0);
    sw_reseq(4'b1111, '0);
    drop_from_run();
    seq_por(4'b1111, '0, 3, 0, 0);
    drop_from_run();
    seq_por(4'b1011, {W'(2), W'(0), W'(5), W'(0)}, 0, 0, 0);
    drop_from_run();
    seq_por(4'b1111, {W'(0), W'(30), W'(0), W'(0)}, 0, 1, STR + 12);
    seq_por(4'b1111, '0, 0, 0, 0);
    drop_from_run();
    seq_por(4'b1111, '0, 0, 2, 300);
    drop_from_run();
    seq_por(4'b0110, rand_dly(), 0, 3, 100);

    for (int it = 0; it < 10; it++) begin
      int mode, arg;
      if (in_run) begin
        if ($urandom_range(0, 1) == 1) sw_reseq(N'($urandom), rand_dly());
        drop_from_run();
      end
      mode = $urandom_range(0, 3);
      case (mode)
        1: arg = $urandom_range(1, STR + 200);
        2: arg = $urandom_range(2, STR - 20);
        3: arg = $urandom_range(1, STR - 2);
        default: arg = 0;
      endcase
      seq_por(N'($urandom), rand_dly(), ($urandom_range(0, 1) == 1) ? $urandom_range(1, FL - 1) : 0,
              mode, arg);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=still running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
